// File: rtl/mac_array_ctrl_if.sv
// Handshake and bus signals between the core FSM, the tile sequencer and the
// 8x8 MAC array. The core/array side uses "master" and the sequencer uses "slave".
interface mac_array_ctrl_if #(
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
);
  logic               start;
  logic               cfg_mode;
  logic [addr_bw-1:0] cfg_w_base;
  logic [addr_bw-1:0] cfg_x_base;
  logic [len_bw-1:0]  cfg_nact;
  logic [col-1:0]     arr_valid;
  logic               rd_en;
  logic [addr_bw-1:0] rd_addr;
  logic [1:0]         inst_w;
  logic               mode;
  logic               busy;
  logic               done;

  modport master (
    output start, cfg_mode, cfg_w_base, cfg_x_base, cfg_nact, arr_valid,
    input  rd_en, rd_addr, inst_w, mode, busy, done
  );

  modport slave (
    input  start, cfg_mode, cfg_w_base, cfg_x_base, cfg_nact, arr_valid,
    output rd_en, rd_addr, inst_w, mode, busy, done
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the weight-stationary MAC array: kernel load, settle,
// activation streaming and output drain, with a watchdog on the drain phase.
module mac_array_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  mac_array_ctrl_if.slave  bus
);

  localparam int SettleCycles = row + col;
  localparam int WdCycles     = 4 * (row + col);
  localparam int WdW          = $clog2(WdCycles + 1);
  localparam int CntW         = (len_bw > WdW) ? len_bw : WdW;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SETTLE,
    EXEC,
    DRAIN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [len_bw:0]    out_cnt_q, out_cnt_d;
  logic [addr_bw-1:0] w_base_q, x_base_q;
  logic [len_bw-1:0]  nact_q;
  logic               mode_q, busy_q;
  logic [1:0]         inst_w_q;

  logic               start_tile;
  logic               rd_en;
  logic [addr_bw-1:0] rd_addr;
  logic [1:0]         tag;
  logic [CntW-1:0]    nk;
  logic [len_bw:0]    out_cnt_inc;
  logic               out_valid;

  assign nk          = mode_q ? CntW'(2 * col) : CntW'(col);
  assign out_valid   = bus.arr_valid[col-1];
  assign out_cnt_inc = out_cnt_q + {{len_bw{1'b0}}, out_valid};

  // cnt_q is reused per phase: read index, settle timer, then drain watchdog.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_cnt_d  = out_cnt_q;
    start_tile = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    tag        = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_tile = 1'b1;
          cnt_d      = '0;
          out_cnt_d  = '0;
          state_d    = LOAD_W;
        end
      end

      LOAD_W: begin
        rd_en   = 1'b1;
        rd_addr = w_base_q + addr_bw'(cnt_q);
        tag     = 2'b01;
        if (cnt_q == nk - CntW'(1)) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      SETTLE: begin
        if (cnt_q == CntW'(SettleCycles - 1)) begin
          cnt_d   = '0;
          state_d = (nact_q == '0) ? DONE : EXEC;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      EXEC: begin
        rd_en     = 1'b1;
        rd_addr   = x_base_q + addr_bw'(cnt_q);
        tag       = 2'b10;
        out_cnt_d = out_cnt_inc;
        if (cnt_q == CntW'(nact_q) - CntW'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      DRAIN: begin
        out_cnt_d = out_cnt_inc;
        cnt_d     = out_valid ? '0 : cnt_q + CntW'(1);
        if ((out_cnt_inc >= (len_bw + 1)'(nact_q)) || (cnt_d == CntW'(WdCycles))) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // inst_w trails the read phase by one cycle to line up with SRAM read data.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_cnt_q <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      nact_q    <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      inst_w_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_cnt_q <= out_cnt_d;
      inst_w_q  <= tag;
      if (start_tile) begin
        w_base_q <= bus.cfg_w_base;
        x_base_q <= bus.cfg_x_base;
        nact_q   <= bus.cfg_nact;
        mode_q   <= bus.cfg_mode;
        busy_q   <= 1'b1;
      end else if (state_q == DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.inst_w  = inst_w_q;
  assign bus.mode    = mode_q;
  assign bus.busy    = busy_q;
  assign bus.done    = (state_q == DONE);

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequencer for the 8x8 weight-stationary MAC array.
- On a start pulse it runs one tile. It reads kernel words from the shared core SRAM and issues the kernel-load instruction (single or packed two-word mode). It then waits for the weights to settle, streams activation vectors with the execute instruction, and counts array valid pulses until every output vector has left the array.
- Sits between the core top-level FSM and the array, and owns inst_w, mode and the SRAM read port during a tile.

Parameters:
- row, 8, array rows
- col, 8, array columns
- addr_bw, 11, SRAM address width
- len_bw, 8, activation-count width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle tile start pulse
- cfg_mode  in  1  0 = one word per kernel column; 1 = packed mode, two words per column
- cfg_w_base  in  addr_bw  first kernel word address
- cfg_x_base  in  addr_bw  first activation word address
- cfg_nact  in  len_bw  activation vectors to stream
- arr_valid  in  col  valid vector from the array
- rd_en  out  1  SRAM read enable (active high)
- rd_addr  out  addr_bw  SRAM read address
- inst_w  out  2  array instruction: bit0 = kernel load, bit1 = execute
- mode  out  1  array mode, held for the whole tile
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-low): state=IDLE; rd_en=0, rd_addr=0, inst_w=00, mode=0, busy=0, done=0; all counters clear.
- Reset mid-tile: immediate return to IDLE with the values above. The array is not flushed; the core re-issues start.
- SRAM read latency is 1 cycle. inst_w is the rd_en-phase instruction delayed by one register, so inst_w is asserted in the cycle the read data reaches the array input.
- IDLE:
  - start=1 latches cfg_* and sets mode<=cfg_mode and busy<=1 → LOAD_W.
  - start while busy is ignored.
- LOAD_W:
  - Issues nk reads: nk = col (mode 0) or 2*col (mode 1).
  - Addresses run cfg_w_base .. cfg_w_base+nk-1; rd_en=1 every cycle.
  - Load phase tag = 01, so inst_w = 01 on each of the nk following cycles.
  - After the last read → SETTLE.
- SETTLE:
  - rd_en=0 for row+col cycles (16 by default); inst_w returns to 00 one cycle after the last load data.
  - When the count expires:
    - cfg_nact=0 → DONE.
    - otherwise → EXEC.
- EXEC:
  - Issues cfg_nact reads at cfg_x_base .. cfg_x_base+cfg_nact-1; tag = 10, so inst_w = 10 one cycle later.
  - After the last read → DRAIN.
- DRAIN:
  - rd_en=0, inst_w=00.
  - The output counter increments on every cycle with arr_valid[col-1]=1; counting is active from EXEC entry, so early valids are counted.
  - Counter == cfg_nact → DONE.
  - Watchdog: if no arr_valid[col-1] arrives for 4*(row+col) consecutive cycles in DRAIN, still → DONE.
- DONE: done=1 for exactly one cycle, busy<=0, mode holds its value → IDLE.
  - start in the same cycle as done is ignored; start the following cycle is accepted.
- Address arithmetic wraps modulo 2^addr_bw; no saturation.
- cfg_* changes while busy have no effect.

Test Plan:
- Reset low mid-EXEC (cycle 5 of 20) → next cycle: rd_en=0, inst_w=00, busy=0, done=0; a fresh start runs the full sequence.
- mode 0, w_base=0x000, x_base=0x040, nact=4, array model returns arr_valid[7] 20 cycles after each execute → 8 reads at 0x000-0x007, then inst_w=01 for 8 cycles; 16 idle cycles; 4 reads at 0x040-0x043, then inst_w=10 for 4 cycles; done 1 cycle after the 4th valid; busy high the whole time.
- mode 1, nact=2 → 16 kernel reads, inst_w=01 for 16 consecutive cycles, mode=1 from the cycle after start until the next start; then 2 execute cycles.
- nact=0 → LOAD_W and SETTLE only, no execute cycles, done exactly row+col cycles after the last load instruction.
- w_base=0x7FE, mode 0 → addresses 0x7FE, 0x7FF, 0x000 … 0x005 (wrap).
- Start pulsed again while busy and on the done cycle → ignored, no extra reads. arr_valid held low in DRAIN → done after 64 idle cycles (watchdog).
